// File: rtl/atpg_scan_seq.sv
// atpg_scan_seq: scan sequencer driving shift/capture controls with overlapped unload/load
module atpg_scan_seq #(
    parameter int NCHAIN = 8,
    parameter int LEN_W  = 10,
    parameter int PAT_W  = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [LEN_W-1:0]  cfg_chain_len,
    input  logic [PAT_W-1:0]  cfg_num_pat,
    input  logic [1:0]        cfg_cap_cnt,
    input  logic              start,
    input  logic              abort,
    input  logic [NCHAIN-1:0] si_data,
    input  logic              si_valid,
    output logic              si_ready,
    input  logic [NCHAIN-1:0] so_chain,
    output logic [NCHAIN-1:0] so_data,
    output logic              so_valid,
    output logic              scan_en,
    output logic              scan_ce,
    output logic              cap_pulse,
    output logic              busy,
    output logic              done,
    output logic              aborted,
    output logic [PAT_W-1:0]  pat_cnt
);
    typedef enum logic [2:0] {IDLE, SHIFT, SE_FALL, CAPTURE, SE_RISE, UNLOAD, DONE} state_t;
    state_t state;
    logic [LEN_W-1:0] len, cnt;
    logic [PAT_W-1:0] num_pat;
    logic [1:0] cap_last, cap_idx;
    logic first;
    logic unused_si;
    assign unused_si = ^si_data;
    // shift strobes follow the handshake directly; the chain itself carries si_data
    always_comb begin
        si_ready = state == SHIFT;
        scan_ce  = si_ready ? si_valid : state == UNLOAD;
        so_valid = scan_ce & ~first;
        so_data  = so_valid ? so_chain : '0;
    end
    // sequencer FSM with registered scan_en/cap_pulse/busy/done/aborted/pat_cnt
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            scan_en   <= 1'b0;
            cap_pulse <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            aborted   <= 1'b0;
            pat_cnt   <= '0;
            cnt       <= '0;
            cap_idx   <= '0;
            cap_last  <= '0;
            len       <= '0;
            num_pat   <= '0;
            first     <= 1'b0;
        end else if (abort && state != IDLE) begin
            state     <= IDLE;
            scan_en   <= 1'b0;
            cap_pulse <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            aborted   <= 1'b1;
        end else begin
            done    <= 1'b0;
            aborted <= 1'b0;
            case (state)
                IDLE: if (start && cfg_chain_len != '0 && cfg_num_pat != '0) begin
                    len      <= cfg_chain_len;
                    num_pat  <= cfg_num_pat;
                    cap_last <= cfg_cap_cnt == 2'd0 ? 2'd0 : cfg_cap_cnt - 2'd1;
                    pat_cnt  <= '0;
                    cnt      <= '0;
                    first    <= 1'b1;
                    scan_en  <= 1'b1;
                    busy     <= 1'b1;
                    state    <= SHIFT;
                end
                SHIFT: if (scan_ce) begin
                    if (cnt == len - 1'b1) begin
                        cnt     <= '0;
                        scan_en <= 1'b0;
                        state   <= SE_FALL;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                SE_FALL: begin
                    cap_idx   <= '0;
                    cap_pulse <= 1'b1;
                    state     <= CAPTURE;
                end
                CAPTURE: if (cap_idx == cap_last) begin
                    cap_pulse <= 1'b0;
                    scan_en   <= 1'b1;
                    first     <= 1'b0;
                    pat_cnt   <= pat_cnt == num_pat ? pat_cnt : pat_cnt + 1'b1;
                    state     <= SE_RISE;
                end else begin
                    cap_idx <= cap_idx + 1'b1;
                end
                SE_RISE: state <= pat_cnt == num_pat ? UNLOAD : SHIFT;
                UNLOAD: if (cnt == len - 1'b1) begin
                    cnt     <= '0;
                    scan_en <= 1'b0;
                    done    <= 1'b1;
                    state   <= DONE;
                end else begin
                    cnt <= cnt + 1'b1;
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_atpg_scan_seq.sv
// tb_atpg_scan_seq: randomized runs checked against per-run totals derived from the sequencing rules
module tb_atpg_scan_seq;
    localparam int NCHAIN = 8;
    localparam int LEN_W  = 10;
    localparam int PAT_W  = 12;
    logic clk = 0, rst = 1, start = 0, abort = 0, si_valid = 0;
    logic [LEN_W-1:0] cfg_chain_len = '0;
    logic [PAT_W-1:0] cfg_num_pat = '0;
    logic [1:0] cfg_cap_cnt = '0;
    logic [NCHAIN-1:0] si_data = '0, so_chain = '0, so_data;
    logic si_ready, so_valid, scan_en, scan_ce, cap_pulse, busy, done, aborted;
    logic [PAT_W-1:0] pat_cnt;
    int n_tests = 0, n_fail = 0;
    int bc, sc;

    atpg_scan_seq #(.NCHAIN(NCHAIN), .LEN_W(LEN_W), .PAT_W(PAT_W)) dut (
        .clk(clk), .rst(rst), .cfg_chain_len(cfg_chain_len), .cfg_num_pat(cfg_num_pat),
        .cfg_cap_cnt(cfg_cap_cnt), .start(start), .abort(abort), .si_data(si_data),
        .si_valid(si_valid), .si_ready(si_ready), .so_chain(so_chain), .so_data(so_data),
        .so_valid(so_valid), .scan_en(scan_en), .scan_ce(scan_ce), .cap_pulse(cap_pulse),
        .busy(busy), .done(done), .aborted(aborted), .pat_cnt(pat_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] outs();
        return 32'({scan_en, scan_ce, cap_pulse, si_ready, so_valid, so_data, busy, done, aborted, pat_cnt});
    endfunction

    task automatic idle_tick();
        @(negedge clk);
        start = 0; abort = 0; rst = 0; si_valid = 0;
        #1;
    endtask

    // mode: 0 si_valid always 1, 1 toggling from the first SHIFT cycle, 2 random with start/cfg noise
    task automatic do_run(input int len, input int np, input int cap, input int mode,
                          input bit ab, input bit rs, output int bc_o, output int sc_o);
        int hs = 0, ub = 0, cc = 0, sf = 0, sr = 0, pre = 0, uu = 0, k = 0, pc = 0;
        bit dn = 0, ax = 0, rsd = 0, fin = 0, capd = 0;
        int capn = cap == 0 ? 1 : cap;
        bc_o = 0; sc_o = 0;
        @(negedge clk);
        cfg_chain_len = LEN_W'(len); cfg_num_pat = PAT_W'(np); cfg_cap_cnt = 2'(cap);
        start = 1;
        for (int t = 0; t < 4000 && !fin; t++) begin
            @(negedge clk);
            start = 0; abort = 0; rst = 0;
            si_valid = mode == 0 ? 1'b1 : mode == 1 ? k % 2 == 0 : $urandom % 3 != 0;
            si_data = NCHAIN'($urandom);
            so_chain = NCHAIN'($urandom);
            #1;
            k++;
            if (rsd) begin
                check("rst_outs", outs(), 0);
                fin = 1;
            end else begin
                if (busy) bc_o++;
                if (si_ready) sc_o++;
                if (si_ready && scan_ce) hs++;
                if (so_valid) ub++;
                if (cap_pulse) begin cc++; capd = 1; end
                if (so_valid && !capd) pre++;
                if (busy && !scan_en && !cap_pulse && !done) sf++;
                if (busy && scan_en && !si_ready && !scan_ce) sr++;
                check("so_data", so_data, so_valid ? so_chain : '0);
                if (si_ready) check("ce_hs", scan_ce, si_valid);
                if (done) begin
                    dn = 1; fin = 1; pc = pat_cnt;
                    check("done_busy", busy, 1);
                    check("done_se", scan_en, 0);
                end
                if (aborted) begin
                    ax = 1; fin = 1;
                    check("ab_outs", {scan_en, cap_pulse, busy, done}, 0);
                    check("ab_pat", pat_cnt, 1);
                end
                if (ab && cap_pulse && pat_cnt == 1) abort = 1;
                if (rs && so_valid && !si_ready && capd && pat_cnt == PAT_W'(np)) begin
                    uu++;
                    if (uu == 3) begin rst = 1; rsd = 1; end
                end
                if (mode == 2 && busy && !fin) begin
                    start = $urandom % 5 == 0;
                    cfg_chain_len = LEN_W'($urandom_range(0, 15));
                    cfg_num_pat = PAT_W'($urandom_range(0, 5));
                    cfg_cap_cnt = 2'($urandom);
                end
            end
        end
        if (!fin) check("timeout", 0, 1);
        if (rs) begin
            check("rst_no_done", dn, 0);
        end else if (ab) begin
            check("ab_seen", ax, 1);
            check("ab_no_done", dn, 0);
            idle_tick();
            check("ab_pulse1", aborted, 0);
        end else begin
            check("hs", hs, np * len);
            check("unload", ub, np * len);
            check("caps", cc, np * capn);
            check("se_fall", sf, np);
            check("se_rise", sr, np);
            check("first_nounload", pre, 0);
            check("busy_len", bc_o, sc_o + np * (2 + capn) + len + 1);
            check("pat_cnt", pc, np);
            idle_tick();
            check("idle_after", {busy, done, scan_en}, 0);
        end
    endtask

    initial begin
        @(posedge clk);
        @(posedge clk);
        #1;
        check("reset", outs(), 0);
        idle_tick();
        do_run(4, 1, 1, 0, 0, 0, bc, sc);
        check("t1_busy12", bc, 12);
        do_run(3, 2, 2, 0, 0, 0, bc, sc);
        do_run(5, 1, 1, 1, 0, 0, bc, sc);
        check("t3_shift9", sc, 9);
        do_run(4, 3, 1, 0, 1, 0, bc, sc);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            cfg_chain_len = LEN_W'(i == 0 ? 0 : 5);
            cfg_num_pat = PAT_W'(i == 0 ? 3 : 0);
            start = 1;
            idle_tick();
            idle_tick();
            check("bad_start", busy, 0);
        end
        do_run(8, 1, 1, 0, 0, 1, bc, sc);
        do_run(8, 1, 1, 0, 0, 0, bc, sc);
        for (int i = 0; i < 8; i++)
            do_run($urandom_range(1, 12), $urandom_range(1, 4), $urandom_range(0, 3), 2, 0, 0, bc, sc);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
